mips_cpu_bus_core: RTL and testbench
====================================

Name: mips_cpu_bus_core

Overview:
- Multi-cycle MIPS-I subset CPU with a single shared Avalon-style memory bus (instruction fetch and data access on one port).
- Sits between the system clock/reset and a bus fabric that maps program memory at 0xBFC00000 and data/stack memory at 0x00000000.
- Runs from the reset vector until it jumps to address 0, then halts and deasserts active.
- Exposes register $2 (v0) for result checking.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset.
- HALT_ADDRESS, 32'h0000_0000, a fetch from this address halts the core.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- active  output  1  high while executing; low once halted.
- register_v0  output  32  current value of GPR $2.
- address  output  32  bus byte address, always word aligned (bits 1:0 = 0).
- write  output  1  bus write request.
- read  output  1  bus read request.
- waitrequest  input  1  slave stall; the request is held while high.
- writedata  output  32  store data.
- byteenable  output  4  byte lanes; bit0 = bits 7:0.
- readdata  input  32  read data, valid in the cycle after the accepted read.

Behaviour:
- Reset (reset low, asynchronous):
  - PC = RESET_VECTOR; all GPRs = 0; state = FETCH; delay-slot flag cleared.
  - Outputs: active = 1, read = 0, write = 0, byteenable = 4'b0000, register_v0 = 0.
- Bus handshake:
  - A request is accepted on the rising edge where read or write is high and waitrequest is low.
  - While waitrequest is high, address, writedata, byteenable, read and write hold stable.
  - read and write are never high together.
  - readdata is sampled exactly one cycle after read acceptance, with read low in that cycle.
- States:
  - FETCH: read = 1, address = PC, byteenable = 1111.
  - FETCH_WAIT: latch readdata as IR.
  - EXEC: decode, ALU, branch resolve, register writeback for non-loads.
  - MEM: LW/SW request, held under waitrequest.
  - MEM_WAIT: load writeback.
  - HALTED.
  - Non-memory instructions go EXEC -> FETCH, so each takes at least 3 cycles.
- Halt:
  - Entered in FETCH when PC == HALT_ADDRESS, with no bus request issued.
  - In HALTED: active = 0, read = write = 0. Only reset exits HALTED.
- Instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, BLEZ, BGTZ.
  - J-type: J, JAL.
  - Any other encoding executes as a NOP.
- Arithmetic and immediates:
  - 32-bit wrap-around arithmetic; no overflow traps.
  - Logical immediates are zero-extended; all other immediates are sign-extended.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned against the sign-extended immediate.
- Register file: writes to $0 are discarded and $0 always reads 0.
- Branch delay slot:
  - Taken branches and jumps set a pending target.
  - The next sequential instruction (the delay slot) executes, then PC = target.
  - Branch target = PC+4 + (sign-extended offset << 2).
  - J/JAL target = {PC+4[31:28], index, 2'b00}.
  - JAL and JALR link PC+8; JAL links into $31.
- Load/store:
  - LW and SW use address = base + sign-extended offset with bits 1:0 forced to 00; misaligned offsets are not trapped.
  - SW drives byteenable = 1111 and writedata = rt.
  - LW result is written to rt in MEM_WAIT; no load delay slot is required.
- Jump-to-zero halt: JR $ra with $ra = 0 executes its delay slot, then halts at the next FETCH.

Optional Feature:
- Macro: MIPS_BYTE_ACCESS_EN.
- Defined: adds LB, LBU, LH, LHU, SB, SH.
  - The word-aligned bus address is used.
  - Stores set byteenable to the addressed lane(s), with writedata replicated across lanes.
  - Loads extract the lane from readdata and sign- or zero-extend it.
  - Byte lane n corresponds to address[1:0] = n (little-endian).
  - Halfword accesses with address[0] = 1 act as NOPs.
- Undefined: those six opcodes execute as NOPs and byteenable is only 0000 or 1111.

Test Plan:
- Reset, then ADDIU $2,$0,-1213; JR $0 + NOP at 0xBFC00000 -> active falls; register_v0 = 0xFFFFFB43.
- Random waitrequest of 1-10 cycles on every access, same program -> identical result; no bus signal changes while stalled.
- SW $2, 0($sp) then LW $3, 0($sp) with $sp = 0x100; ADDU $2,$3,$0 -> bus write at 0x100 with byteenable 1111; v0 = stored value.
- BEQ $0,$0,+2 with ADDIU $2,$2,1 in the delay slot and ADDIU $2,$2,100 skipped -> v0 = 1.
- JAL to a subroutine that sets v0 = 7 and returns via JR $31 -> $31 = JAL PC+8; v0 = 7; halt on JR $0.
- Assert reset low mid-LW with waitrequest high -> read drops immediately; restart fetch at 0xBFC00000 after release.

Source files
------------

// File: rtl/mips_cpu_bus_core.sv
// Multi-cycle MIPS-I subset CPU on a single Avalon-style bus (fetch and data share the port).
// Define MIPS_BYTE_ACCESS_EN to add LB/LBU/LH/LHU/SB/SH; otherwise those opcodes are NOPs.
module mips_cpu_bus_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [2:0] {FETCH, FETCH_WAIT, EXEC, MEM, MEM_WAIT, HALTED} state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDIU = 6'h09,
                           OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21,
                           OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28,
                           OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    state_t      state, state_next;
    logic [31:0] pc, ir, branch_target;
    logic        branch_pending;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val, simm, zimm, pc_plus4, ea;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign simm     = {{16{ir[15]}}, ir[15:0]};
    assign zimm     = {16'h0000, ir[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign ea       = rs_val + simm;

    assign register_v0 = regs[2];

    logic        exec_wb_en, take, mem_op, mem_load;
    logic [4:0]  exec_wb_idx;
    logic [31:0] exec_wb_data, target;

    always_comb begin
        exec_wb_en   = 1'b0;
        exec_wb_idx  = rd;
        exec_wb_data = '0;
        take         = 1'b0;
        target       = pc_plus4 + {simm[29:0], 2'b00};
        mem_op       = 1'b0;
        mem_load     = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                exec_wb_en = 1'b1;
                case (funct)
                    F_SLL:  exec_wb_data = rt_val << shamt;
                    F_SRL:  exec_wb_data = rt_val >> shamt;
                    F_SRA:  exec_wb_data = 32'($signed(rt_val) >>> shamt);
                    F_SLLV: exec_wb_data = rt_val << rs_val[4:0];
                    F_SRLV: exec_wb_data = rt_val >> rs_val[4:0];
                    F_SRAV: exec_wb_data = 32'($signed(rt_val) >>> rs_val[4:0]);
                    F_JR: begin
                        exec_wb_en = 1'b0;
                        take       = 1'b1;
                        target     = rs_val;
                    end
                    F_JALR: begin
                        take         = 1'b1;
                        target       = rs_val;
                        exec_wb_data = pc + 32'd8;
                    end
                    F_ADDU: exec_wb_data = rs_val + rt_val;
                    F_SUBU: exec_wb_data = rs_val - rt_val;
                    F_AND:  exec_wb_data = rs_val & rt_val;
                    F_OR:   exec_wb_data = rs_val | rt_val;
                    F_XOR:  exec_wb_data = rs_val ^ rt_val;
                    F_NOR:  exec_wb_data = ~(rs_val | rt_val);
                    F_SLT:  exec_wb_data = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: exec_wb_data = {31'b0, rs_val < rt_val};
                    default: exec_wb_en = 1'b0;
                endcase
            end
            OP_J: begin
                take   = 1'b1;
                target = {pc_plus4[31:28], ir[25:0], 2'b00};
            end
            OP_JAL: begin
                take         = 1'b1;
                target       = {pc_plus4[31:28], ir[25:0], 2'b00};
                exec_wb_en   = 1'b1;
                exec_wb_idx  = 5'd31;
                exec_wb_data = pc + 32'd8;
            end
            OP_BEQ:  take = (rs_val == rt_val);
            OP_BNE:  take = (rs_val != rt_val);
            OP_BLEZ: take = rs_val[31] || (rs_val == '0);
            OP_BGTZ: take = !rs_val[31] && (rs_val != '0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                exec_wb_en  = 1'b1;
                exec_wb_idx = rt;
                case (opcode)
                    OP_ADDIU: exec_wb_data = rs_val + simm;
                    OP_SLTI:  exec_wb_data = {31'b0, $signed(rs_val) < $signed(simm)};
                    OP_SLTIU: exec_wb_data = {31'b0, rs_val < simm};
                    OP_ANDI:  exec_wb_data = rs_val & zimm;
                    OP_ORI:   exec_wb_data = rs_val | zimm;
                    OP_XORI:  exec_wb_data = rs_val ^ zimm;
                    default:  exec_wb_data = {ir[15:0], 16'h0000};
                endcase
            end
            OP_LW: begin
                mem_op   = 1'b1;
                mem_load = 1'b1;
            end
            OP_SW: mem_op = 1'b1;
`ifdef MIPS_BYTE_ACCESS_EN
            OP_LB, OP_LBU: begin
                mem_op   = 1'b1;
                mem_load = 1'b1;
            end
            // Misaligned halfwords skip the bus entirely and retire as NOPs.
            OP_LH, OP_LHU: begin
                mem_op   = !ea[0];
                mem_load = 1'b1;
            end
            OP_SB: mem_op = 1'b1;
            OP_SH: mem_op = !ea[0];
`endif
            default: ;
        endcase
    end

    logic [3:0]  store_be;
    logic [31:0] store_data, load_data;

    always_comb begin
        store_be   = 4'b1111;
        store_data = rt_val;
        load_data  = readdata;
`ifdef MIPS_BYTE_ACCESS_EN
        case (opcode)
            OP_SB: begin
                store_be   = 4'b0001 << ea[1:0];
                store_data = {4{rt_val[7:0]}};
            end
            OP_SH: begin
                store_be   = ea[1] ? 4'b1100 : 4'b0011;
                store_data = {2{rt_val[15:0]}};
            end
            default: ;
        endcase
        case (opcode)
            OP_LB:   load_data = 32'($signed(readdata[8*ea[1:0] +: 8]));
            OP_LBU:  load_data = {24'h0, readdata[8*ea[1:0] +: 8]};
            OP_LH:   load_data = 32'($signed(readdata[16*ea[1] +: 16]));
            OP_LHU:  load_data = {16'h0, readdata[16*ea[1] +: 16]};
            default: ;
        endcase
`endif
    end

    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;

    always_comb begin
        wb_en   = 1'b0;
        wb_idx  = exec_wb_idx;
        wb_data = exec_wb_data;
        if (state == EXEC) begin
            wb_en = exec_wb_en;
        end else if (state == MEM_WAIT) begin
            wb_en   = 1'b1;
            wb_idx  = rt;
            wb_data = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read       = 1'b0;
        write      = 1'b0;
        address    = pc;
        byteenable = '0;
        writedata  = '0;
        active     = (state != HALTED);
        case (state)
            FETCH: begin
                if (pc == HALT_ADDRESS) begin
                    state_next = HALTED;
                end else begin
                    read       = 1'b1;
                    byteenable = 4'b1111;
                    if (!waitrequest) state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: state_next = EXEC;
            EXEC:       state_next = mem_op ? MEM : FETCH;
            MEM: begin
                address = ea & 32'hFFFF_FFFC;
                if (mem_load) begin
                    read       = 1'b1;
                    byteenable = 4'b1111;
                end else begin
                    write      = 1'b1;
                    byteenable = store_be;
                    writedata  = store_data;
                end
                if (!waitrequest) state_next = mem_load ? MEM_WAIT : FETCH;
            end
            MEM_WAIT: state_next = FETCH;
            HALTED:   state_next = HALTED;
            default:  state_next = FETCH;
        endcase
        // Reset forces FETCH, so requests are masked directly while it is held.
        if (!reset) begin
            read       = 1'b0;
            write      = 1'b0;
            byteenable = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_VECTOR;
            ir             <= '0;
            branch_pending <= 1'b0;
            branch_target  <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (state == FETCH_WAIT) ir <= readdata;
            if (state == EXEC) begin
                pc             <= branch_pending ? branch_target : pc_plus4;
                branch_pending <= take;
                branch_target  <= target;
            end
            if (wb_en && (wb_idx != 5'd0)) regs[wb_idx] <= wb_data;
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Scoreboard bench for mips_cpu_bus_core: directed programs, bus-write and halt events checked by a monitor.
module tb_mips_cpu_bus_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    mips_cpu_bus_core #(.RESET_VECTOR(32'hBFC0_0000), .HALT_ADDRESS(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    initial forever #5 clk = ~clk;

    logic [31:0] prog [64];
    logic [31:0] dmem [256];
    int unsigned n_cmp = 0, n_fail = 0;
    bit          stall_en = 1'b0, force_wait = 1'b0, slave_busy = 1'b0;

    typedef struct {
        bit          is_halt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ev_t;
    ev_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:28] == 4'hB) return prog[a[7:2]];
        return dmem[a[9:2]];
    endfunction

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        ev_t e;
        e.is_halt = 1'b0; e.addr = a; e.data = d; e.be = b;
        expq.push_back(e);
    endtask

    task automatic push_halt(input logic [31:0] v0);
        ev_t e;
        e.is_halt = 1'b1; e.addr = '0; e.data = v0; e.be = '0;
        expq.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    endtask

    // Bus slave: accepts at the posedge when a request is up with waitrequest low.
    initial begin
        logic        acc_rd, acc_wr;
        logic [31:0] a, d;
        logic [3:0]  b;
        int unsigned cnt;
        cnt = 0;
        waitrequest = 1'b0;
        readdata = '0;
        forever begin
            @(negedge clk);
            acc_rd = reset && read && !waitrequest;
            acc_wr = reset && write && !waitrequest;
            a = address; d = writedata; b = byteenable;
            @(posedge clk);
            #1;
            if (acc_rd) readdata = mem_read(a);
            if (acc_wr) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) dmem[a[9:2]][8*k +: 8] = d[8*k +: 8];
            end
            if (acc_rd || acc_wr) slave_busy = 1'b0;
            if (force_wait) begin
                waitrequest = 1'b1;
            end else if (!stall_en || !(read || write)) begin
                waitrequest = 1'b0;
            end else begin
                if (!slave_busy) begin
                    slave_busy = 1'b1;
                    cnt = $urandom_range(1, 10);
                end
                if (cnt > 0) begin
                    waitrequest = 1'b1;
                    cnt--;
                end else begin
                    waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and on the halt edge.
    initial begin
        logic        prev_act, prev_stall;
        logic [31:0] s_addr, s_data;
        logic [5:0]  s_ctl;
        ev_t         e;
        prev_act = 1'b1;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_act = active;
                prev_stall = 1'b0;
                continue;
            end
            if (read || write) check("rd_wr_exclusive", {31'b0, read && write}, 32'h0);
            if (prev_stall) begin
                check("stall_address", address, s_addr);
                check("stall_writedata", writedata, s_data);
                check("stall_ctl", {26'b0, read, write, byteenable}, {26'b0, s_ctl});
            end
            prev_stall = (read || write) && waitrequest;
            s_addr = address; s_data = writedata; s_ctl = {read, write, byteenable};
            if (write && !waitrequest) begin
                if (expq.size() == 0 || expq[0].is_halt) begin
                    n_cmp++; n_fail++;
                    $display("FAIL bus_write: got write %h@%h, expected no write", writedata, address);
                end else begin
                    e = expq.pop_front();
                    check("write_addr", address, e.addr);
                    check("write_data", writedata, e.data);
                    check("write_be", {28'b0, byteenable}, {28'b0, e.be});
                end
            end
            if (prev_act && !active) begin
                if (expq.size() == 0 || !expq[0].is_halt) begin
                    n_cmp++; n_fail++;
                    $display("FAIL halt: got halt with v0=%h, expected pending bus write", register_v0);
                end else begin
                    e = expq.pop_front();
                    check("halt_v0", register_v0, e.data);
                end
            end
            prev_act = active;
        end
    end

    task automatic assert_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        slave_busy = 1'b0;
        #1;
        check("rst_active", {31'b0, active}, 32'h1);
        check("rst_read", {31'b0, read}, 32'h0);
        check("rst_write", {31'b0, write}, 32'h0);
        check("rst_be", {28'b0, byteenable}, 32'h0);
        check("rst_v0", register_v0, 32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        force_wait = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("first_fetch_read", {31'b0, read}, 32'h1);
        check("first_fetch_addr", address, 32'hBFC0_0000);
    endtask

    task automatic wait_halt(input string name);
        int cyc;
        cyc = 0;
        while (active && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (active) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got active=1 after %0d cycles, expected halt", name, cyc);
        end
        repeat (2) @(negedge clk);
        check({name, "_leftover"}, 32'(expq.size()), 32'h0);
        expq.delete();
    endtask

    task automatic run(input string name);
        assert_reset();
        release_reset();
        wait_halt(name);
    endtask

    task automatic load_t1();
        clear_mem();
        prog[0] = i_op(6'h09, 0, 2, 16'hFB43);      // addiu $2,$0,-1213
        prog[1] = r_op(0, 0, 0, 0, 6'h08);          // jr $0
        push_halt(32'hFFFF_FB43);
    endtask

    task automatic load_t2();
        clear_mem();
        prog[0] = i_op(6'h09, 0, 29, 16'h0100);     // addiu $sp,$0,0x100
        prog[1] = i_op(6'h0F, 0, 2, 16'h1234);      // lui $2,0x1234
        prog[2] = i_op(6'h0D, 2, 2, 16'h5678);      // ori $2,$2,0x5678
        prog[3] = i_op(6'h2B, 29, 2, 16'h0000);     // sw $2,0($sp)
        prog[4] = i_op(6'h09, 0, 2, 16'h0000);      // addiu $2,$0,0
        prog[5] = i_op(6'h23, 29, 3, 16'h0000);     // lw $3,0($sp)
        prog[6] = r_op(3, 0, 2, 0, 6'h21);          // addu $2,$3,$0
        prog[7] = r_op(0, 0, 0, 0, 6'h08);          // jr $0
        push_write(32'h0000_0100, 32'h1234_5678, 4'hF);
        push_halt(32'h1234_5678);
    endtask

    task automatic load_t3();
        clear_mem();
        prog[0] = i_op(6'h04, 0, 0, 16'd2);         // beq $0,$0,+2
        prog[1] = i_op(6'h09, 2, 2, 16'd1);         // addiu $2,$2,1 (delay slot)
        prog[2] = i_op(6'h09, 2, 2, 16'd100);       // skipped
        prog[3] = r_op(0, 0, 0, 0, 6'h08);          // jr $0
        push_halt(32'h1);
    endtask

    task automatic load_t4();
        clear_mem();
        prog[0]  = j_op(6'h03, 32'hBFC0_0020);      // jal sub
        prog[2]  = i_op(6'h2B, 0, 31, 16'h0000);    // sw $31,0($0)
        prog[3]  = r_op(0, 0, 0, 0, 6'h08);         // jr $0
        prog[8]  = i_op(6'h09, 0, 2, 16'd7);        // sub: addiu $2,$0,7
        prog[9]  = r_op(31, 0, 0, 0, 6'h08);        // jr $31
        push_write(32'h0000_0000, 32'hBFC0_0008, 4'hF);
        push_halt(32'h7);
    endtask

    task automatic load_t5();
        logic [31:0] exp_vals [10];
        exp_vals = '{32'h0000_000B, 32'hFFFF_FFFC, 32'h0000_000F, 32'h0000_0001, 32'h0000_0000,
                     32'h0000_0004, 32'h0000_0018, 32'h0000_0001, 32'h0000_FFF8, 32'h0000_8003};
        clear_mem();
        prog[0]  = i_op(6'h09, 0, 4, 16'hFFF8);     // $4 = -8
        prog[1]  = i_op(6'h09, 0, 5, 16'h0003);     // $5 = 3
        prog[2]  = r_op(5, 4, 6, 0, 6'h23);         // subu $6,$5,$4
        prog[3]  = r_op(0, 4, 7, 1, 6'h03);         // sra $7,$4,1
        prog[4]  = r_op(0, 4, 8, 28, 6'h02);        // srl $8,$4,28
        prog[5]  = r_op(4, 5, 9, 0, 6'h2A);         // slt $9,$4,$5
        prog[6]  = r_op(4, 5, 10, 0, 6'h2B);        // sltu $10,$4,$5
        prog[7]  = r_op(4, 5, 11, 0, 6'h27);        // nor $11,$4,$5
        prog[8]  = r_op(5, 5, 12, 0, 6'h04);        // sllv $12,$5,$5
        prog[9]  = i_op(6'h0B, 5, 13, 16'hFFFF);    // sltiu $13,$5,-1
        prog[10] = i_op(6'h0C, 4, 14, 16'hFFFF);    // andi $14,$4,0xffff
        prog[11] = i_op(6'h0E, 5, 15, 16'h8000);    // xori $15,$5,0x8000
        for (int k = 0; k < 10; k++) begin
            prog[12 + k] = i_op(6'h2B, 0, 5'(6 + k), 16'(16 + 4 * k));
            push_write(32'(16 + 4 * k), exp_vals[k], 4'hF);
        end
        prog[22] = r_op(6, 7, 2, 0, 6'h21);         // addu $2,$6,$7
        prog[23] = r_op(0, 0, 0, 0, 6'h08);         // jr $0
        push_halt(32'h7);
    endtask

    task automatic reset_mid_load();
        int cyc;
        clear_mem();
        prog[0] = i_op(6'h09, 0, 29, 16'h0100);     // addiu $sp,$0,0x100
        prog[1] = i_op(6'h23, 29, 3, 16'h0000);     // lw $3,0($sp)
        prog[2] = r_op(0, 0, 0, 0, 6'h08);          // jr $0
        stall_en = 1'b1;
        assert_reset();
        release_reset();
        cyc = 0;
        while (!(read && address == 32'h0000_0100 && waitrequest) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("lw_stall_seen", {31'b0, read && address == 32'h0000_0100 && waitrequest}, 32'h1);
        force_wait = 1'b1;
        #2 reset = 1'b0;
        slave_busy = 1'b0;
        #1;
        check("midlw_read_drop", {31'b0, read}, 32'h0);
        check("midlw_be", {28'b0, byteenable}, 32'h0);
        check("midlw_active", {31'b0, active}, 32'h1);
        release_reset();
        push_halt(32'h0);
        wait_halt("midlw");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stall_en = 1'b0; load_t1(); run("t1_nostall");
        stall_en = 1'b1; load_t1(); run("t1_stall");
        stall_en = 1'b1; load_t2(); run("t2_swlw");
        stall_en = 1'b0; load_t3(); run("t3_beq");
        stall_en = 1'b1; load_t4(); run("t4_jal");
        stall_en = 1'b0; load_t5(); run("t5_alu");
        stall_en = 1'b1; load_t5(); run("t5_alu_stall");
        reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
